mips_hazard_unit: RTL and testbench

- Parametrised hazard-control block for the 5-stage pipelined MIPS core (IF, ID, EX, MEM, WB).
- Keeps its own scoreboard of the destination register and control bits for the instructions in EX, MEM and WB.
- Drives the stall, bubble, flush and EX-operand forward-select signals for the IF/ID and ID/EX pipeline registers and the PC.
- Generalises fixed, always-enabled pipeline registers into hazard-aware advancement: load-use stall, branch/jump flush, operand forwarding, plus a stall counter.

---
 rtl/mips_pipe_pkg.sv | 49 ++++
 rtl/hazard_fwd_mux_sel.sv | 27 ++
 rtl/mips_hazard_unit.sv | 139 +++++++++++++
 tb/tb_mips_hazard_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared definitions for the MIPS 5-stage pipeline control.
//   - Forward-select encodings for the EX operand muxes.
//   - Scoreboard entry types for the EX, MEM and WB stages.
//   - Default register-address width and a "writes register" helper.
// The scoreboard structs are sized by REG_ADDR_WIDTH_DEFAULT; a core using a
// different register-address width changes that constant here.
package mips_pipe_pkg;

    localparam int REG_ADDR_WIDTH_DEFAULT = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    typedef logic [REG_ADDR_WIDTH_DEFAULT-1:0] reg_addr_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t dst;
        logic      rw;
        logic      mr;
    } sb_ex_t;

    typedef struct packed {
        logic      v;
        reg_addr_t dst;
        logic      rw;
        logic      mr;
    } sb_mem_t;

    typedef struct packed {
        logic      v;
        reg_addr_t dst;
        logic      rw;
    } sb_wb_t;

    // True when a live entry will write register r. The zero register is
    // hardwired, so it never produces a value worth waiting for.
    function automatic logic writes_reg(input logic      v,
                                        input logic      rw,
                                        input reg_addr_t dst,
                                        input reg_addr_t r,
                                        input reg_addr_t zero);
        return v & rw & (dst != zero) & (dst == r);
    endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// hazard_fwd_mux_sel: forward-source selector for one EX operand.
// Ports:
//   ex_src_i   source register read by the instruction in EX
//   mem_i      MEM-stage scoreboard entry
//   wb_i       WB-stage scoreboard entry
//   fwd_sel_o  FWD_REGFILE / FWD_EXMEM / FWD_MEMWB
// MEM is checked first so the youngest producer of a register wins.
module hazard_fwd_mux_sel
    import mips_pipe_pkg::*;
#(
    parameter reg_addr_t ZERO_REG = '0
) (
    input  reg_addr_t  ex_src_i,
    input  sb_mem_t    mem_i,
    input  sb_wb_t     wb_i,
    output logic [1:0] fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_REGFILE;
        if (writes_reg(mem_i.v, mem_i.rw, mem_i.dst, ex_src_i, ZERO_REG))
            fwd_sel_o = FWD_EXMEM;
        else if (writes_reg(wb_i.v, wb_i.rw, wb_i.dst, ex_src_i, ZERO_REG))
            fwd_sel_o = FWD_MEMWB;
    end

endmodule

// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: hazard control for the 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destination registers in a private scoreboard and drives
// PC/IF-ID hold, IF-ID flush, ID-EX bubble, EX forward selects and a
// saturating count of stall cycles.
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   id_*                    decoded fields of the instruction in ID
//   ex_branch_taken         branch/jr in EX resolved taken
//   id_jump                 j/jal decoded in ID
//   pc_hold, if_id_hold     freeze fetch and ID
//   if_id_flush             IF/ID loads a NOP
//   id_ex_bubble            ID/EX loads zeroed control
//   fwd_a_sel, fwd_b_sel    EX operand sources (see mips_pipe_pkg)
//   stall_count             saturating count of data-hazard stall cycles
// Build option HAZARD_FORWARDING_EN:
//   defined   - forwarding from MEM/WB; only load-use stalls.
//   undefined - no forwarding (selects tied to regfile); stall while any
//               instruction in EX or MEM writes a source used in ID.
module mips_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = REG_ADDR_WIDTH_DEFAULT,
    parameter int ZERO_REG        = 0,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rt,
    input  logic                       id_uses_rs,
    input  logic                       id_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0]  id_dst,
    input  logic                       id_reg_write,
    input  logic                       id_mem_read,
    input  logic                       ex_branch_taken,
    input  logic                       id_jump,
    output logic                       pc_hold,
    output logic                       if_id_hold,
    output logic                       if_id_flush,
    output logic                       id_ex_bubble,
    output logic [1:0]                 fwd_a_sel,
    output logic [1:0]                 fwd_b_sel,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam reg_addr_t ZR = reg_addr_t'(ZERO_REG);

    sb_ex_t  ex_q, ex_d;
    sb_mem_t mem_q;
    sb_wb_t  wb_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    reg_addr_t rs_a, rt_a, dst_a;
    assign rs_a  = reg_addr_t'(id_rs);
    assign rt_a  = reg_addr_t'(id_rt);
    assign dst_a = reg_addr_t'(id_dst);

    // Producers ahead of ID that target a source ID actually reads.
    logic ex_hits, mem_hits;
    assign ex_hits  = (id_uses_rs & writes_reg(ex_q.v, ex_q.rw, ex_q.dst, rs_a, ZR))
                    | (id_uses_rt & writes_reg(ex_q.v, ex_q.rw, ex_q.dst, rt_a, ZR));
    assign mem_hits = (id_uses_rs & writes_reg(mem_q.v, mem_q.rw, mem_q.dst, rs_a, ZR))
                    | (id_uses_rt & writes_reg(mem_q.v, mem_q.rw, mem_q.dst, rt_a, ZR));

    logic stall, bubble;
    logic [1:0] fwd_a, fwd_b;

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; one bubble moves it to
    // MEM, from where MEM/WB forwarding covers the consumer.
    assign stall = id_valid & ex_q.mr & ex_hits;

    hazard_fwd_mux_sel #(.ZERO_REG(ZR)) u_fwd_a (
        .ex_src_i  (ex_q.rs),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .fwd_sel_o (fwd_a)
    );

    hazard_fwd_mux_sel #(.ZERO_REG(ZR)) u_fwd_b (
        .ex_src_i  (ex_q.rt),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .fwd_sel_o (fwd_b)
    );
`else
    // Without forwarding the consumer waits until the producer reaches WB,
    // where the write-before-read register file resolves it.
    assign stall = id_valid & (ex_hits | mem_hits);
    assign fwd_a = FWD_REGFILE;
    assign fwd_b = FWD_REGFILE;
`endif

    // A taken branch squashes ID, so a stall for it is pointless.
    assign bubble = stall | ex_branch_taken;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.v   = id_valid;
            ex_d.rs  = rs_a;
            ex_d.rt  = rt_a;
            ex_d.dst = dst_a;
            ex_d.rw  = id_reg_write;
            ex_d.mr  = id_mem_read;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !ex_branch_taken && stall_cnt_q != {STALL_CNT_WIDTH{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= '{v: ex_q.v, dst: ex_q.dst, rw: ex_q.rw, mr: ex_q.mr};
            wb_q        <= '{v: mem_q.v, dst: mem_q.dst, rw: mem_q.rw};
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Inputs from ID/EX can toggle while reset is held; keep outputs quiet.
    assign pc_hold      = ~reset & stall & ~ex_branch_taken;
    assign if_id_hold   = ~reset & stall & ~ex_branch_taken;
    assign if_id_flush  = ~reset & (ex_branch_taken | id_jump);
    assign id_ex_bubble = ~reset & bubble;
    assign fwd_a_sel    = reset ? FWD_REGFILE : fwd_a;
    assign fwd_b_sel    = reset ? FWD_REGFILE : fwd_b;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
module tb_mips_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       ex_branch_taken, id_jump;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_count;

    logic       s_pc_hold, s_if_id_hold, s_if_id_flush, s_id_ex_bubble;
    logic [1:0] s_fwd_a_sel, s_fwd_b_sel;
    logic [3:0] sat_count;

    mips_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    mips_hazard_unit #(.STALL_CNT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
        .pc_hold(s_pc_hold), .if_id_hold(s_if_id_hold), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall_count(sat_count)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int LU_STALLS = FWD ? 1 : 2;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, dst;
        logic       urs, urt, rw, mr, jmp, br;
    } instr_t;

    typedef struct {
        logic        hold, flush, bubble;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                  input logic [4:0] rt, input logic urt,
                                  input logic [4:0] dst, input logic rw, input logic mr);
        instr_t i;
        i = '{v: v, rs: rs, rt: rt, dst: dst, urs: urs, urt: urt, rw: rw, mr: mr,
              jmp: 1'b0, br: 1'b0};
        return i;
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.v;  id_rs = i.rs;  id_rt = i.rt;  id_dst = i.dst;
        id_uses_rs = i.urs;  id_uses_rt = i.urt;
        id_reg_write = i.rw;  id_mem_read = i.mr;
        id_jump = i.jmp;  ex_branch_taken = i.br;
    endtask

    // Expected outputs are queued with the stimulus and retired once the
    // combinational outputs have settled.
    task automatic push_exp(input logic hold, input logic flush, input logic bubble,
                            input logic [1:0] fa, input logic [1:0] fb, input int cnt);
        exp_t e;
        e = '{hold: hold, flush: flush, bubble: bubble, fa: fa, fb: fb, cnt: 16'(cnt)};
        exp_q.push_back(e);
    endtask

    task automatic retire(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ":queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ":pc_hold"},      32'(pc_hold),      32'(e.hold));
        chk({tag, ":if_id_hold"},   32'(if_id_hold),   32'(e.hold));
        chk({tag, ":if_id_flush"},  32'(if_id_flush),  32'(e.flush));
        chk({tag, ":id_ex_bubble"}, 32'(id_ex_bubble), 32'(e.bubble));
        chk({tag, ":fwd_a_sel"},    32'(fwd_a_sel),    32'(e.fa));
        chk({tag, ":fwd_b_sel"},    32'(fwd_b_sel),    32'(e.fb));
        chk({tag, ":stall_count"},  32'(stall_count),  32'(e.cnt));
    endtask

    // Present one instruction in ID for nst stall cycles, then let it advance.
    task automatic issue(input string tag, input instr_t i, input int nst,
                         input logic [1:0] fa, input logic [1:0] fb);
        for (int k = 0; k < nst; k++) begin
            @(negedge clk);
            drive(i);
            push_exp(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, exp_cnt);
            #1 retire({tag, "_stall"});
            exp_cnt++;
        end
        @(negedge clk);
        drive(i);
        push_exp(1'b0, 1'b0, 1'b0, fa, fb, exp_cnt);
        #1 retire(tag);
    endtask

    instr_t nop, lw8, add988, add8, sub9, or10, add0, add300, jmp_i, br_i, jbr_i;

    // lw $8,0($0); add $9,$8,$8; two nops to drain.
    task automatic load_use_seq(input string tag);
        issue({tag, "_lw"},   lw8,    0,         2'b00, 2'b00);
        issue({tag, "_add"},  add988, LU_STALLS, 2'b00, 2'b00);
        issue({tag, "_nop1"}, nop,    0,         FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
        issue({tag, "_nop2"}, nop,    0,         2'b00, 2'b00);
    endtask

    initial begin
        nop    = mk(0, 0, 0, 0, 0, 0, 0, 0);
        lw8    = mk(1, 0, 1, 8, 0, 8, 1, 1);
        add988 = mk(1, 8, 1, 8, 1, 9, 1, 0);
        add8   = mk(1, 1, 1, 2, 1, 8, 1, 0);
        sub9   = mk(1, 8, 1, 3, 1, 9, 1, 0);
        or10   = mk(1, 8, 1, 9, 1, 10, 1, 0);
        add0   = mk(1, 1, 1, 2, 1, 0, 1, 0);
        add300 = mk(1, 0, 1, 0, 1, 3, 1, 0);
        jmp_i  = mk(1, 0, 0, 0, 0, 0, 0, 0);  jmp_i.jmp = 1'b1;
        br_i   = add988;                      br_i.br   = 1'b1;
        jbr_i  = nop;  jbr_i.jmp = 1'b1;      jbr_i.br  = 1'b1;

        // Reset: outputs stay low even with a jump on the inputs.
        reset = 1'b1;
        drive(jmp_i);
        #1;
        push_exp(0, 0, 0, 2'b00, 2'b00, 0);
        retire("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(nop);

        load_use_seq("lu");

        // add $8 ; sub $9,$8,$3 ; or $10,$8,$9
        issue("chain_add", add8, 0,              2'b00, 2'b00);
        issue("chain_sub", sub9, FWD ? 0 : 2,    2'b00, 2'b00);
        issue("chain_or",  or10, FWD ? 0 : 2,    FWD ? 2'b01 : 2'b00, 2'b00);
        issue("chain_nop", nop,  0,              FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00);

        // $0 as destination never creates a dependency.
        issue("zero_add0", add0,   0, 2'b00, 2'b00);
        issue("zero_add3", add300, 0, 2'b00, 2'b00);
        issue("zero_nop",  nop,    0, 2'b00, 2'b00);

        // Taken branch overrides a pending load-use stall.
        issue("br_lw", lw8, 0, 2'b00, 2'b00);
        @(negedge clk);
        drive(br_i);
        push_exp(0, 1, 1, 2'b00, 2'b00, exp_cnt);
        #1 retire("br_over_stall");
        issue("br_nop", nop, 0, 2'b00, 2'b00);

        // Jump alone flushes IF/ID only; with a taken branch, the branch rule.
        @(negedge clk);
        drive(jmp_i);
        push_exp(0, 1, 0, 2'b00, 2'b00, exp_cnt);
        #1 retire("jump");
        issue("jump_nop", nop, 0, 2'b00, 2'b00);
        @(negedge clk);
        drive(jbr_i);
        push_exp(0, 1, 1, 2'b00, 2'b00, exp_cnt);
        #1 retire("jump_br");
        issue("jump_br_nop", nop, 0, 2'b00, 2'b00);

        chk("sat_pre", 32'(sat_count), 32'(exp_cnt));

        // Enough stalls to pin the 4-bit counter at all-ones.
        for (int n = 0; n < 20; n++) load_use_seq("sat");
        chk("sat_hold", 32'(sat_count), 32'hF);

        // Asynchronous reset in the middle of a stall.
        issue("rst_lw", lw8, 0, 2'b00, 2'b00);
        @(negedge clk);
        drive(add988);
        push_exp(1, 0, 1, 2'b00, 2'b00, exp_cnt);
        #1 retire("rst_pre");
        reset = 1'b1;
        id_jump = 1'b1;
        exp_cnt = 0;
        push_exp(0, 0, 0, 2'b00, 2'b00, 0);
        #1 retire("rst_mid");
        chk("rst_sat_cnt", 32'(sat_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(add988);
        push_exp(0, 0, 0, 2'b00, 2'b00, 0);
        #1 retire("rst_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
